spi_master: RTL and testbench
=============================

# spi_master

Byte-wide SPI master that executes the single-byte transfers requested by the counter front end. It takes a byte and a one-cycle `start` strobe, serialises it MSB-first on `mosi` with a generated `sclk`, and captures `miso` into `rx_data`. It reports completion with `done` and `ready`. Slave select is not driven here; the requesting stage owns `SS` and frames multi-byte transactions itself.

## Interface
- `CLK_DIV`, default 50: system clocks per SCLK half-period; legal range ≥ 1. The default gives 1 MHz SCLK at 100 MHz.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 = sample on leading edge; 1 = shift on leading edge, sample on trailing edge.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: transfer request. Sampled only while `ready`=1.
- `tx_data` input 8: byte to send. Latched in the cycle `start` is accepted.
- `miso` input 1: serial data from slave.
- `sclk` output 1: SPI clock. Registered.
- `mosi` output 1: serial data to slave, MSB first. Registered.
- `rx_data` output 8: last received byte. Updated only at transfer end.
- `ready` output 1: high when idle and able to accept `start`.
- `done` output 1: one-cycle pulse at transfer end.

## Operation
- The FSM has three states: IDLE, FIRST_HALF, SECOND_HALF. A bit counter runs 7→0 and a divider counter runs 0..CLK_DIV-1.
- **IDLE:**
  - `ready`=1 and `sclk`=CPOL.
  - On `start`=1, latch `tx_data` into the shift register, load bit counter = 7 and go to FIRST_HALF.
- **FIRST_HALF** (lasts CLK_DIV cycles):
  - `sclk` = CPOL when CPHA=0, ~CPOL when CPHA=1.
  - `mosi` = current MSB of the shift register.
  - On the last divider cycle, capture `miso` into the receive shift register LSB and go to SECOND_HALF.
- **SECOND_HALF** (lasts CLK_DIV cycles):
  - `sclk` = ~CPOL when CPHA=0, CPOL when CPHA=1.
  - On the last divider cycle:
    - If bit counter > 0: shift the tx register left, decrement the bit counter and go to FIRST_HALF.
    - If bit counter = 0: go to IDLE, copy the receive register to `rx_data`, and pulse `done`.
- `done` and `ready` rise in the same cycle. A `start` in that same cycle or in any later idle cycle is accepted.
- A `start` while `ready`=0 is ignored: no queueing, no error.
- `tx_data` changes after acceptance do not affect the byte in flight.
- `mosi` holds its last driven value in IDLE.
- Reset values: `sclk`=CPOL, `mosi`=0, `rx_data`=0x00, `ready`=1, `done`=0, state IDLE, all counters 0.
- Reset asserted mid-transfer aborts immediately: no `done`, `rx_data` cleared, `sclk` returns to CPOL.

## Timing
- Cycle 0 is the cycle in which `start`=1 and `ready`=1 are sampled.
- **Cycle 1:**
  - `ready`=0.
  - `mosi`=tx_data[7].
  - `sclk` at its FIRST_HALF level.
- Bit k (k = 0 for the MSB) occupies cycles 1+2k·CLK_DIV through (2k+2)·CLK_DIV.
- `miso` for bit k is the value sampled at the clock edge ending cycle (2k+1)·CLK_DIV.
- **Cycle 1+16·CLK_DIV:**
  - `done`=1, `ready`=1, `rx_data` valid, `sclk`=CPOL.
- Total occupancy is 16·CLK_DIV cycles; back-to-back throughput is one byte per 16·CLK_DIV+1 cycles.
- SCLK edges always fall on divider boundaries. With CPHA=0 there are 8 leading and 8 trailing edges; the final trailing edge coincides with the return to IDLE.
- CLK_DIV=1 is legal. SCLK is then clk/2 and there is no sub-cycle glitching, because every output is registered.

## Structure
- Package `spi_pkg` holds:
  - the `spi_state_t` enum (IDLE, FIRST_HALF, SECOND_HALF);
  - the localparam bit width 8;
  - mode constants SPI_MODE0..SPI_MODE3 as {CPOL,CPHA} pairs.
- One sub-module: `spi_half_tick`. It is a CLK_DIV divider with synchronous clear on transfer accept and a one-cycle `half_end` output. It is reused by the future SPI slave testbench model.
- The shift registers, bit counter and FSM live in `spi_master`.

## Test plan
- Mode 0, CLK_DIV=2, `tx_data`=0xA5, `miso` loopback from `mosi`:
  - `mosi` shows 1,0,1,0,0,1,0,1 on 8 rising `sclk` edges.
  - `done` at cycle 33, `rx_data`=0xA5.
- Two-byte frame as issued by the counter stage (count=0x1234; `start` 2 cycles after each `done`):
  - both starts are accepted;
  - the bytes transmitted are 0x12 then 0x34;
  - exactly two `done` pulses.
- `start` pulsed at cycles 5 and 20 during a busy transfer: ignored, with exactly one `done` and unchanged `rx_data` sequence.
- Modes 1, 2 and 3 with CLK_DIV=1, slave model returning 0x3C: `sclk` idle level and sample edge match the mode, `rx_data`=0x3C every time.
- `reset` asserted at cycle 9 of a transfer:
  - `sclk`=CPOL, `ready`=1, `rx_data`=0x00 and no `done` pulse.
  - A following `start` with 0xFF completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its divider sub-block.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FIRST_HALF  = 2'd1,
    SECOND_HALF = 2'd2
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled and flags the last cycle.
module spi_half_tick
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic half_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign half_end = enable && !clear && (count == LAST);

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master: MSB-first transmit on mosi, miso captured into rx_data at transfer end.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | ready, sclk parked at CPOL, waiting for start
// FIRST_HALF  | first SCLK half of a bit; miso sampled on its last cycle
// SECOND_HALF | second SCLK half; advance to next bit or finish the byte
module spi_master
  import spi_pkg::*;
#(
  parameter int   CLK_DIV = 50,
  parameter logic CPOL    = 1'b0,
  parameter logic CPHA    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 ready,
  output logic                 done
);

  localparam int BW = $clog2(SPI_WIDTH);
  localparam logic [BW-1:0] BIT_MAX = BW'(SPI_WIDTH - 1);
  localparam logic FH_LVL = CPOL ^ CPHA;
  localparam logic SH_LVL = ~(CPOL ^ CPHA);

  spi_state_t state, state_next;

  logic                 half_end;
  logic                 accept, capture, advance, finish;
  logic [BW-1:0]        bit_cnt;
  logic [SPI_WIDTH-2:0] tx_shift;  // bits still to send after the one on mosi
  logic [SPI_WIDTH-1:0] rx_shift;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (state != IDLE),
    .half_end (half_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FIRST_HALF;
        end
      end
      FIRST_HALF: begin
        if (half_end) begin
          capture    = 1'b1;
          state_next = SECOND_HALF;
        end
      end
      SECOND_HALF: begin
        if (half_end) begin
          if (bit_cnt != '0) begin
            advance    = 1'b1;
            state_next = FIRST_HALF;
          end else begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        tx_shift <= tx_data[SPI_WIDTH-2:0];
        bit_cnt  <= BIT_MAX;
        sclk     <= FH_LVL;
        mosi     <= tx_data[SPI_WIDTH-1];
      end
      if (capture) begin
        rx_shift <= {rx_shift[SPI_WIDTH-2:0], miso};
        sclk     <= SH_LVL;
      end
      if (advance) begin
        tx_shift <= {tx_shift[SPI_WIDTH-3:0], 1'b0};
        bit_cnt  <= bit_cnt - 1'b1;
        sclk     <= FH_LVL;
        mosi     <= tx_shift[SPI_WIDTH-2];
      end
      if (finish) begin
        rx_data <= rx_shift;
        sclk    <= CPOL;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances (modes 0..3), an SPI slave model and a done-driven scoreboard.
module tb_spi_master;
  import spi_pkg::*;

  localparam int N = 4;
  localparam logic [1:0] MODES [N] = '{SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};

  typedef struct {
    int         inst;
    logic [7:0] rx;
    logic [7:0] tx;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] start, miso, sclk, mosi, ready, done;
  logic [7:0]   tx_data [N];
  logic [7:0]   rx_data [N];

  logic [N-1:0] loop, slv_go, slv_miso, sclk_prev, go_prev;
  logic [7:0]   slv_out [N];
  logic [7:0]   slv_cap [N];
  int           slv_idx [N];
  int           slv_edges [N];
  int           slv_samp [N];

  exp_t exp_q [$];
  int   done_cnt [N];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic cpol_of(int i);
    logic [1:0] m;
    m = MODES[i];
    return m[1];
  endfunction

  function automatic logic cpha_of(int i);
    logic [1:0] m;
    m = MODES[i];
    return m[0];
  endfunction

  function automatic int div_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam logic [1:0] M = MODES[g];
    spi_master #(.CLK_DIV((g == 0) ? 2 : 1), .CPOL(M[1]), .CPHA(M[0])) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start[g]),
      .tx_data (tx_data[g]),
      .miso    (miso[g]),
      .sclk    (sclk[g]),
      .mosi    (mosi[g]),
      .rx_data (rx_data[g]),
      .ready   (ready[g]),
      .done    (done[g])
    );
    assign miso[g] = loop[g] ? mosi[g] : slv_miso[g];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: samples mosi on the mode's sample edge, shifts miso on the other edge.
  always @(sclk or slv_go) begin
    for (int i = 0; i < N; i++) begin
      if (slv_go[i] !== go_prev[i]) begin
        slv_idx[i]   = 0;
        slv_edges[i] = 0;
        slv_samp[i]  = 0;
        slv_cap[i]   = 8'h00;
        slv_miso[i]  = cpha_of(i) ? 1'b0 : slv_out[i][7];
      end else if (sclk[i] !== sclk_prev[i] && !reset) begin
        logic lead;
        lead = (sclk[i] != cpol_of(i));
        slv_edges[i]++;
        if (lead == !cpha_of(i)) begin
          slv_cap[i] = {slv_cap[i][6:0], mosi[i]};
          slv_samp[i]++;
        end else if (!cpha_of(i)) begin
          slv_idx[i]++;
          if (slv_idx[i] < 8) slv_miso[i] = slv_out[i][7 - slv_idx[i]];
        end else begin
          if (slv_idx[i] < 8) slv_miso[i] = slv_out[i][7 - slv_idx[i]];
          slv_idx[i]++;
        end
      end
    end
    sclk_prev = sclk;
    go_prev   = slv_go;
  end

  // Scoreboard monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(i) + 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_inst",   i, e.inst);
            check("rx_data",     rx_data[i], e.rx);
            check("mosi_byte",   slv_cap[i], e.tx);
            check("done_cycle",  cyc, e.done_cyc);
            check("done_ready",  ready[i], 1'b1);
            check("done_sclk",   sclk[i], cpol_of(i));
            check("sclk_edges",  slv_edges[i], 16);
            check("sample_edges", slv_samp[i], 8);
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [7:0] tx, input logic [7:0] slv, input bit push);
    int w;
    int acc;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ready[i] && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!ready[i]) begin
      check("ready_wait", ready[i], 1'b1);
      return;
    end
    slv_out[i] = slv;
    slv_go[i]  = ~slv_go[i];
    tx_data[i] = tx;
    start[i]   = 1'b1;
    @(posedge clk);
    #1;
    start[i]   = 1'b0;
    acc        = cyc;
    tx_data[i] = 8'($urandom);
    check("c1_ready", ready[i], 1'b0);
    check("c1_mosi",  mosi[i], tx[7]);
    check("c1_sclk",  sclk[i], cpol_of(i) ^ cpha_of(i));
    if (push) begin
      e.inst     = i;
      e.rx       = loop[i] ? tx : slv;
      e.tx       = tx;
      e.done_cyc = acc + 16 * div_of(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int i);
    int w;
    w = 0;
    @(negedge clk);
    while (!done[i] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("done_wait", done[i], 1'b1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    start  = '0;
    loop   = '0;
    slv_go = '0;
    for (int i = 0; i < N; i++) begin
      tx_data[i]  = 8'h00;
      slv_out[i]  = 8'h00;
      done_cnt[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_sclk",  sclk[i], cpol_of(i));
      check("rst_mosi",  mosi[i], 1'b0);
      check("rst_rx",    rx_data[i], 8'h00);
      check("rst_ready", ready[i], 1'b1);
      check("rst_done",  done[i], 1'b0);
    end
    reset = 1'b0;

    // Mode 0 loopback
    loop[0] = 1'b1;
    issue(0, 8'hA5, 8'h00, 1'b1);
    drain();

    // Two-byte frame, start two cycles after each done
    d0 = done_cnt[0];
    issue(0, 8'h12, 8'h00, 1'b1);
    wait_done(0);
    @(negedge clk);
    issue(0, 8'h34, 8'h00, 1'b1);
    wait_done(0);
    drain();
    check("frame_dones", done_cnt[0] - d0, 2);

    // Starts while busy are ignored
    d0 = done_cnt[0];
    issue(0, 8'hC3, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    tx_data[0] = 8'h0F;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0]   = 1'b0;
    repeat (14) @(negedge clk);
    tx_data[0] = 8'hF0;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0]   = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("busy_dones", done_cnt[0] - d0, 1);
    check("busy_rx", rx_data[0], 8'hC3);

    // Modes 1..3, CLK_DIV=1, slave returns 0x3C
    for (int i = 1; i < N; i++) begin
      for (int r = 0; r < 3; r++) begin
        issue(i, 8'($urandom), 8'h3C, 1'b1);
        drain();
      end
      check("idle_sclk", sclk[i], cpol_of(i));
    end

    // Randomized traffic on every instance against the slave model
    loop[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 4; r++) begin
        issue(i, 8'($urandom), 8'($urandom), 1'b1);
        if ($urandom_range(0, 1) == 1) wait_done(i);
      end
      drain();
    end

    // Reset in cycle 9 of a transfer
    loop[0] = 1'b1;
    issue(0, 8'h5A, 8'h00, 1'b1);
    drain();
    d0 = done_cnt[0];
    issue(0, 8'($urandom_range(1, 255)), 8'h00, 1'b0);
    repeat (8) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_sclk",  sclk[0], cpol_of(0));
    check("abort_ready", ready[0], 1'b1);
    check("abort_rx",    rx_data[0], 8'h00);
    check("abort_done",  done[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt[0] - d0, 0);
    issue(0, 8'hFF, 8'h00, 1'b1);
    drain();
    check("post_abort_rx", rx_data[0], 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
